// File: rtl/data_ram_responder.sv
// Word-organised data RAM responder: one request at a time, byte-lane writes, registered reads.
// Latency: acceptance to ready_o is WAIT_CYCLES+1 cycles; no new request is accepted until IDLE after RESP.
module data_ram_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [31:0] ram_addr_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_data_i,
  output logic [31:0] ram_data_o,
  output logic        ready_o,
  output logic        addr_err_o
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]           r_mem [0:DEPTH-1];
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_err;
  logic [31:0]           r_rdata;

  logic [31:0]           w_off;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_in_idx;
  logic                  w_accept;
  logic                  w_enter_resp;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_rd_we;
  logic                  w_rd_err;
  logic                  w_unused;

  // Range test is done on 33 bits so a window ending at 4 GiB does not wrap.
  assign w_off      = ram_addr_i - BASE_ADDR;
  assign w_in_range = ({1'b0, ram_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, ram_addr_i} < LIMIT);
  assign w_in_idx   = w_off[ADDR_WIDTH+1:2];
  assign w_unused   = ^{w_off[31:ADDR_WIDTH+2], w_off[1:0]};

  assign w_accept     = (r_state == S_IDLE) && ram_ce_i;
  assign w_enter_resp = (w_accept && NO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With no wait states the read happens on the acceptance edge, so use the live request.
  assign w_rd_idx = (r_state == S_IDLE) ? w_in_idx    : r_idx;
  assign w_rd_we  = (r_state == S_IDLE) ? ram_we_i    : r_we;
  assign w_rd_err = (r_state == S_IDLE) ? !w_in_range : r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
      r_wdata <= 32'd0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ram_ce_i) begin
            r_we    <= ram_we_i;
            r_sel   <= ram_sel_i;
            r_wdata <= ram_data_i;
            r_idx   <= w_in_idx;
            r_err   <= !w_in_range;
            r_cnt   <= WAIT_LOAD;
            r_state <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_enter_resp && !w_rd_we) begin
        r_rdata <= w_rd_err ? 32'd0 : r_mem[w_rd_idx];
      end
    end
  end

  // Write commits on the edge that leaves RESP; a reset on that edge drops it.
  always_ff @(posedge clk_i) begin
    if (rst_i && (r_state == S_RESP) && r_we && !r_err) begin
      for (int n = 0; n < 4; n++) begin
        if (r_sel[n]) begin
          r_mem[r_idx][8*n +: 8] <= r_wdata[8*n +: 8];
        end
      end
    end
  end

  assign ram_data_o = r_rdata;
  assign ready_o    = (r_state == S_RESP);
  assign addr_err_o = (r_state == S_RESP) && r_err;

endmodule
